// File: rtl/wb_pipeline_ram_slave_pkg.sv
// Shared Wishbone definitions for the pipelined RAM slave: bus width defaults
// and the response codes carried down the response pipe.
package wb_pipeline_ram_slave_pkg;

    localparam int WB_DATA_WIDTH_DEF = 32;
    localparam int WB_ADDR_WIDTH_DEF = 32;
    localparam int RESP_CODE_W       = 2;

    // Termination kind for one accepted request.
    typedef enum logic [RESP_CODE_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2
    } resp_code_e;

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-latency response pipe: one {valid, code, data} entry per accepted
// request, shifted one stage per clock; flush empties every stage at the next edge.
module wb_resp_pipe
    import wb_pipeline_ram_slave_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DW           = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_vld,
    input  logic [RESP_CODE_W-1:0] in_code,
    input  logic [DW-1:0]          in_data,
    output logic                   out_vld,
    output logic [RESP_CODE_W-1:0] out_code,
    output logic [DW-1:0]          out_data
);

    logic [READ_LATENCY-1:0]                  vld_d,  vld_q;
    logic [READ_LATENCY-1:0][RESP_CODE_W-1:0] code_d, code_q;
    logic [READ_LATENCY-1:0][DW-1:0]          data_d, data_q;

    // Next-state: load stage 0 from the accept, shift the rest, or clear on flush.
    always_comb begin
        vld_d     = '0;
        code_d    = '0;
        data_d    = '0;
        if (!flush) begin
            vld_d[0]  = in_vld;
            code_d[0] = in_vld ? in_code : RESP_NONE;
            data_d[0] = in_vld ? in_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_d[i]  = vld_q[i-1];
                code_d[i] = code_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Pipe registers; reset drops every in-flight response immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            code_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            code_q <= code_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q[READ_LATENCY-1];
    assign out_code = code_q[READ_LATENCY-1];
    assign out_data = data_q[READ_LATENCY-1];

endmodule

// File: rtl/wb_pipeline_ram_slave.sv
// Wishbone B4 pipelined RAM slave: byte-laned word RAM, out-of-range error
// termination, fixed-latency in-order responses and an outstanding-request limit
// that drives stall.
module wb_pipeline_ram_slave
    import wb_pipeline_ram_slave_pkg::*;
#(
    parameter int WB_BUS_WIDTH    = WB_DATA_WIDTH_DEF,
    parameter int WB_ADDR_WIDTH   = WB_ADDR_WIDTH_DEF,
    parameter int DEPTH           = 64,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_reset_i,
    input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
    input  logic [WB_BUS_WIDTH-1:0]   wb_data_i,
    input  logic [WB_BUS_WIDTH/8-1:0] wb_sel_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic                      wb_lock_i,
    output logic [WB_BUS_WIDTH-1:0]   wb_data_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_stall_o,
    output logic                      wb_rty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SEL_W = WB_BUS_WIDTH / 8;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [WB_BUS_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic                    accept;
    logic                    wr_en;
    resp_code_e              in_code;
    logic [WB_BUS_WIDTH-1:0] rd_data;
    logic                    pipe_vld;
    logic [RESP_CODE_W-1:0]  pipe_code;
    logic [WB_BUS_WIDTH-1:0] pipe_data;
    logic                    resp_now;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    unused_lock;

    // Lock has no meaning for a single-port RAM.
    assign unused_lock = wb_lock_i;

    assign idx      = wb_addr_i[IDX_W-1:0];
    assign in_range = (wb_addr_i >> IDX_W) == '0;

    // Responses only count while the cycle is alive; once cyc drops the
    // abandoned requests never terminate.
    assign resp_now   = pipe_vld & wb_cyc_i;
    // A response leaving this cycle frees a slot, so a full counter need not stall.
    assign wb_stall_o = wb_cyc_i & (cnt_q == CNT_MAX) & ~resp_now;
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign wr_en      = accept & wb_we_i & in_range;
    assign in_code    = in_range ? RESP_ACK : RESP_ERR;
    // Read data is captured into the pipe at the accept edge; writes and
    // errors carry zero so data_o stays clean for them.
    assign rd_data    = (accept & ~wb_we_i & in_range) ? mem_q[idx] : '0;

    wb_resp_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DW           (WB_BUS_WIDTH)
    ) u_resp_pipe (
        .clk      (wb_clk_i),
        .rst_n    (wb_reset_i),
        .flush    (~wb_cyc_i),
        .in_vld   (accept),
        .in_code  (in_code),
        .in_data  (rd_data),
        .out_vld  (pipe_vld),
        .out_code (pipe_code),
        .out_data (pipe_data)
    );

    assign wb_ack_o  = resp_now & (pipe_code == RESP_ACK);
    assign wb_err_o  = resp_now & (pipe_code == RESP_ERR);
    assign wb_data_o = wb_ack_o ? pipe_data : '0;
    assign wb_rty_o  = 1'b0;

    // Byte-laned RAM write; contents survive reset on purpose.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb_sel_i[b]) mem_q[idx][b*8 +: 8] <= wb_data_i[b*8 +: 8];
            end
        end
    end

    // Outstanding count: up on accept, down on response, cleared when cyc drops.
    always_comb begin
        cnt_d = cnt_q;
        if (!wb_cyc_i)              cnt_d = '0;
        else if (accept && !resp_now) cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && resp_now) cnt_d = cnt_q - CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
        if (!wb_reset_i) cnt_q <= '0;
        else             cnt_q <= cnt_d;
    end

endmodule

// File: tb/tb_wb_pipeline_ram_slave.sv
// Directed bench: default slave (latency 2, limit 4) plus a latency-3,
// limit-1 instance for the stall cadence.
module tb_wb_pipeline_ram_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cyc1 = 0, stb1 = 0, we1 = 0;
    logic [31:0] addr1 = 0, dat1 = 0;
    logic [3:0]  sel1 = 0;
    logic [31:0] q1;
    logic        ack1, err1, stall1, rty1;

    logic        cyc2 = 0, stb2 = 0, we2 = 0;
    logic [31:0] addr2 = 0, dat2 = 0;
    logic [3:0]  sel2 = 0;
    logic [31:0] q2;
    logic        ack2, err2, stall2, rty2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_pipeline_ram_slave u_dut (
        .wb_clk_i (clk), .wb_reset_i (rst_n),
        .wb_addr_i (addr1), .wb_data_i (dat1), .wb_sel_i (sel1),
        .wb_cyc_i (cyc1), .wb_stb_i (stb1), .wb_we_i (we1), .wb_lock_i (1'b0),
        .wb_data_o (q1), .wb_ack_o (ack1), .wb_err_o (err1),
        .wb_stall_o (stall1), .wb_rty_o (rty1)
    );

    wb_pipeline_ram_slave #(.READ_LATENCY(3), .MAX_OUTSTANDING(1)) u_dut2 (
        .wb_clk_i (clk), .wb_reset_i (rst_n),
        .wb_addr_i (addr2), .wb_data_i (dat2), .wb_sel_i (sel2),
        .wb_cyc_i (cyc2), .wb_stb_i (stb2), .wb_we_i (we2), .wb_lock_i (1'b0),
        .wb_data_o (q2), .wb_ack_o (ack2), .wb_err_o (err2),
        .wb_stall_o (stall2), .wb_rty_o (rty2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Expected {ack, err, stall, data} for the default instance this cycle.
    task automatic exp1(input string tag, input logic ea, input logic ee,
                        input logic es, input logic [31:0] ed);
        chk(tag, {29'd0, ack1, err1, stall1, q1}, {29'd0, ea, ee, es, ed});
    endtask

    task automatic step1(input logic c, input logic s, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        @(posedge clk); #1;
        cyc1 = c; stb1 = s; we1 = we; addr1 = a; dat1 = d; sel1 = sel;
        @(negedge clk);
    endtask

    task automatic step2(input logic c, input logic s, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        @(posedge clk); #1;
        cyc2 = c; stb2 = s; we2 = we; addr2 = a; dat2 = d; sel2 = sel;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w2 [4];
        int          n_ack;
        w2[0] = 32'h0BAD_0000; w2[1] = 32'h1111_2222;
        w2[2] = 32'h3333_4444; w2[3] = 32'h5555_6666;

        // Reset: outputs quiet even with a request presented.
        cyc1 = 1; stb1 = 1;
        #3;
        exp1("rst_out", 0, 0, 0, 32'h0);
        chk("rst_rty", {63'd0, rty1}, 64'd0);
        cyc1 = 0; stb1 = 0;
        #9 rst_n = 1;

        // 1: idle cycle, no strobes.
        for (int i = 0; i < 10; i++) begin
            step1(1, 0, 0, 0, 0, 0);
            exp1("t1_idle", 0, 0, 0, 32'h0);
        end

        // 2: full write, upper-half write, read-after-write.
        step1(1, 1, 1, 32'h3, 32'h1122_3344, 4'b1111); exp1("t2_w0", 0, 0, 0, 32'h0);
        step1(1, 1, 1, 32'h3, 32'hAABB_0000, 4'b1100); exp1("t2_w1", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h3, 32'h0, 4'b1111);         exp1("t2_w0_ack", 1, 0, 0, 32'h0);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t2_w1_ack", 1, 0, 0, 32'h0);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t2_rd", 1, 0, 0, 32'hAABB_3344);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t2_end", 0, 0, 0, 32'h0);

        // 3: top in-range word, first out-of-range word, high-bit out-of-range.
        step1(1, 1, 1, 32'h3F, 32'hCAFE_F00D, 4'b1111); exp1("t3_w3f", 0, 0, 0, 32'h0);
        step1(1, 1, 1, 32'h07, 32'h7777_AAAA, 4'b1111); exp1("t3_w7", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h40, 32'h0, 4'b1111);         exp1("t3_w3f_ack", 1, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h3F, 32'h0, 4'b1111);         exp1("t3_w7_ack", 1, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h8000_0003, 32'h0, 4'b1111);  exp1("t3_err40", 0, 1, 0, 32'h0);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t3_rd3f", 1, 0, 0, 32'hCAFE_F00D);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t3_err_hi", 0, 1, 0, 32'h0);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t3_end", 0, 0, 0, 32'h0);

        // 5: abandon a burst; a stray stb without cyc must not write.
        step1(1, 1, 0, 32'h03, 32'h0, 4'b1111);         exp1("t5_r0", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h07, 32'h0, 4'b1111);         exp1("t5_r1", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h3F, 32'h0, 4'b1111);         exp1("t5_r0_ack", 1, 0, 0, 32'hAABB_3344);
        step1(0, 1, 1, 32'h03, 32'hDEAD_BEEF, 4'b1111); exp1("t5_drop", 0, 0, 0, 32'h0);
        step1(0, 0, 0, 0, 0, 0);                        exp1("t5_gone", 0, 0, 0, 32'h0);
        chk("t5_cnt", {60'd0, u_dut.cnt_q}, 64'd0);
        step1(1, 1, 0, 32'h07, 32'h0, 4'b1111);         exp1("t5_new", 0, 0, 0, 32'h0);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t5_no_stale", 0, 0, 0, 32'h0);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t5_new_ack", 1, 0, 0, 32'h7777_AAAA);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t5_end", 0, 0, 0, 32'h0);

        // 4: latency 3, limit 1. Writes spaced to the 3-cycle cadence.
        for (int i = 0; i < 4; i++) begin
            step2(1, 1, 1, i, w2[i], 4'b1111);
            chk("t4_wr_stall", {63'd0, stall2}, 64'd0);
            chk("t4_wr_ack", {63'd0, ack2}, (i == 0) ? 64'd0 : 64'd1);
            step2(1, 0, 0, 0, 0, 0);
            step2(1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) step2(1, 0, 0, 0, 0, 0);
        n_ack = 0;
        for (int t = 0; t < 14; t++) begin
            if (t <= 9) step2(1, 1, 0, t / 3, 0, 4'b1111);
            else        step2(1, 0, 0, 0, 0, 0);
            chk("t4_stall", {63'd0, stall2}, (t % 3 != 0 && t < 13) ? 64'd1 : 64'd0);
            if (ack2) n_ack++;
            if (t % 3 == 0 && t > 0)
                chk("t4_rsp", {31'd0, ack2, err2, q2}, {31'd0, 1'b1, 1'b0, w2[t/3 - 1]});
            else
                chk("t4_quiet", {31'd0, ack2, err2, q2}, 64'd0);
        end
        chk("t4_nack", n_ack, 4);
        step2(0, 0, 0, 0, 0, 0);

        // 6: reset in the middle of a burst, accepted write survives.
        step1(1, 1, 1, 32'h09, 32'h9999_0001, 4'b1111); exp1("t6_w9", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h03, 32'h0, 4'b1111);         exp1("t6_r3", 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        addr1 = 32'h07;
        #1 exp1("t6_pre", 1, 0, 0, 32'h0);
        rst_n = 0;
        #1 exp1("t6_rst", 0, 0, 0, 32'h0);
        @(negedge clk);
        cyc1 = 0; stb1 = 0;
        @(posedge clk); #2 rst_n = 1;
        step1(1, 1, 0, 32'h09, 32'h0, 4'b1111);         exp1("t6_r9", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h07, 32'h0, 4'b1111);         exp1("t6_r7", 0, 0, 0, 32'h0);
        step1(1, 1, 0, 32'h03, 32'h0, 4'b1111);         exp1("t6_r9_ack", 1, 0, 0, 32'h9999_0001);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t6_r7_ack", 1, 0, 0, 32'h7777_AAAA);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t6_r3_ack", 1, 0, 0, 32'hAABB_3344);
        step1(1, 0, 0, 0, 0, 0);                        exp1("t6_end", 0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
